// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: register-address width, the x0 constant,
// the hazard-controller FSM state type and a register-match helper.
package riscv_pipe_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

   // Multiply-sequencing states of the hazard controller
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_RUN  = 2'd1,
      ST_MUL_DONE = 2'd2
   } hz_state_e;

   // True when a source register matches a destination that is not x0
   function automatic logic reg_match(input logic [REG_ADDR_W-1:0] i_dst,
                                      input logic [REG_ADDR_W-1:0] i_src);
      return (i_dst == i_src) && (i_dst != REG_X0);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: the instruction in ID/EX is a load whose
// destination (never x0) is a source of the instruction now in ID.
module load_use_detect
   import riscv_pipe_pkg::*;
(
   input  logic                  i_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] i_ex_writereg,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   output logic                  o_load_use
);

   logic w_match_rs1;
   logic w_match_rs2;

   assign w_match_rs1 = reg_match(i_ex_writereg, i_id_rs1);
   assign w_match_rs2 = reg_match(i_ex_writereg, i_id_rs2);
   assign o_load_use  = i_ex_mem_read & (w_match_rs1 | w_match_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stalls on load-use hazards and sequences a
// multi-cycle multiplier, freezing the front of the pipe while it runs.
module pipeline_hazard_ctrl
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_activate_mul,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_writereg,
   output logic                  pc_stall,
   output logic                  if_id_stall,
   output logic                  id_ex_bubble,
   output logic                  id_ex_hold,
   output logic                  mul_start,
   output logic                  mul_busy,
   output logic                  mul_result_valid,
   output logic [15:0]           stall_cycles
);

   // Counter reload so that MUL_RUN lasts exactly MUL_LATENCY cycles
   localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

   hz_state_e   r_state;
   hz_state_e   w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        r_mul_start;
   logic [15:0] r_stall_cycles;

   logic        w_load_use;
   logic        w_accept;
   logic        w_pc_stall;
   logic        w_bubble;
   logic        w_hold;

   load_use_detect u_load_use_detect (
      .i_ex_mem_read (ex_mem_read),
      .i_ex_writereg (ex_writereg),
      .i_id_rs1      (id_rs1),
      .i_id_rs2      (id_rs2),
      .o_load_use    (w_load_use)
   );

   // State, countdown and start-pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_mul_start <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_mul_start <= w_accept;
      end
   end

   // Next-state and stall decode; MUL_RUN deliberately ignores ID/EX inputs
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_pc_stall  = 1'b0;
      w_bubble    = 1'b0;
      w_hold      = 1'b0;
      case (r_state)
         ST_MUL_RUN: begin
            w_pc_stall = 1'b1;
            w_hold     = 1'b1;
            if (r_cnt == 4'd0) begin
               w_state_nxt = ST_MUL_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_IDLE, ST_MUL_DONE: begin
            if (w_load_use) begin
               w_pc_stall  = 1'b1;
               w_bubble    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (id_activate_mul) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_MUL_RUN;
               w_cnt_nxt   = CNT_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Saturating count of cycles in which the PC is held
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cycles <= 16'd0;
      end else if (w_pc_stall && (r_stall_cycles != 16'hFFFF)) begin
         r_stall_cycles <= r_stall_cycles + 16'd1;
      end else begin
         r_stall_cycles <= r_stall_cycles;
      end
   end

   // Combinational controls are masked so every output reads 0 during reset
   assign pc_stall         = w_pc_stall & ~reset;
   assign if_id_stall      = w_pc_stall & ~reset;
   assign id_ex_bubble     = w_bubble & ~reset;
   assign id_ex_hold       = w_hold & ~reset;
   assign mul_busy         = (r_state == ST_MUL_RUN) & ~reset;
   assign mul_result_valid = (r_state == ST_MUL_DONE) & ~reset;
   assign mul_start        = r_mul_start;
   assign stall_cycles     = r_stall_cycles;

endmodule
